// File: rtl/uart_pkg.sv
// Shared UART RX definitions: field encodings, frame limits and the captured
// frame configuration record.
package uart_pkg;

   localparam int MIN_PRESCALE = 4;
   localparam int MIN_DATA     = 5;
   localparam int MAX_DATA     = 8;
   localparam int MAX_FRAME    = 12;

   typedef enum logic [1:0] {
      FIELD_START  = 2'd0,
      FIELD_DATA   = 2'd1,
      FIELD_PARITY = 2'd2,
      FIELD_STOP   = 2'd3
   } field_t;

   typedef struct packed {
      logic [3:0] data_len;
      logic       par_en;
      logic       stop2;
   } frame_cfg_t;

   function automatic logic [3:0] clamp_data(input logic [3:0] d);
      if (d < 4'(MIN_DATA))      return 4'(MIN_DATA);
      else if (d > 4'(MAX_DATA)) return 4'(MAX_DATA);
      else                       return d;
   endfunction

   // Start + data + optional parity + stop(s); 7..12 for a clamped config.
   function automatic logic [3:0] frame_len(input frame_cfg_t c);
      return 4'd2 + c.data_len + {3'b0, c.par_en} + {3'b0, c.stop2};
   endfunction

endpackage

// File: rtl/rx_sample_decode.sv
// Combinational decode of sample strobes, bit/frame completion and the
// current field from the frame counters and the captured configuration.
module rx_sample_decode
   import uart_pkg::*;
#(
   parameter int PWIDTH = 6,
   parameter int BWIDTH = 4
) (
   input  logic              busy,
   input  logic [PWIDTH-1:0] edge_counter,
   input  logic [BWIDTH-1:0] bit_counter,
   input  logic [PWIDTH-1:0] prescale,
   input  frame_cfg_t        cfg,
   output logic [1:0]        field,
   output logic [2:0]        samp_strobe,
   output logic              bit_done,
   output logic              frame_done
);

   logic [PWIDTH-1:0] half;
   logic [BWIDTH-1:0] last_bit;
   logic [BWIDTH-1:0] dlen;
   field_t            fld;

   assign half     = prescale >> 1;
   assign last_bit = BWIDTH'(frame_len(cfg)) - BWIDTH'(1);
   assign dlen     = BWIDTH'(cfg.data_len);

   // Captured prescale is at least 4, so half-1 never underflows and
   // half+1 never passes the last edge of the bit.
   assign samp_strobe[0] = busy && (edge_counter == half - PWIDTH'(1));
   assign samp_strobe[1] = busy && (edge_counter == half);
   assign samp_strobe[2] = busy && (edge_counter == half + PWIDTH'(1));

   assign bit_done   = busy && (edge_counter == prescale - PWIDTH'(1));
   assign frame_done = bit_done && (bit_counter == last_bit);

   always_comb begin
      fld = FIELD_STOP;
      if (!busy || bit_counter == '0)                   fld = FIELD_START;
      else if (bit_counter <= dlen)                     fld = FIELD_DATA;
      else if (cfg.par_en && bit_counter == dlen + BWIDTH'(1)) fld = FIELD_PARITY;
   end

   assign field = fld;

endmodule

// File: rtl/rx_frame_timer.sv
// UART RX frame timer: edge/bit counters over a whole frame, with config
// captured at frame start and decoded strobes for the sampler and checkers.
module rx_frame_timer
   import uart_pkg::*;
#(
   parameter int PWIDTH = 6,
   parameter int BWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [PWIDTH-1:0] prescale,
   input  logic [3:0]        data_len,
   input  logic              par_en,
   input  logic              stop2,
   output logic [PWIDTH-1:0] edge_counter,
   output logic [BWIDTH-1:0] bit_counter,
   output logic [1:0]        field,
   output logic              busy,
   output logic [2:0]        samp_strobe,
   output logic              bit_done,
   output logic              frame_done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nxt;
   logic [PWIDTH-1:0] edge_cnt, edge_nxt;
   logic [BWIDTH-1:0] bit_cnt, bit_nxt;
   logic [PWIDTH-1:0] p_cfg, p_nxt;
   frame_cfg_t        cfg, cfg_nxt;
   logic              capture;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         edge_cnt <= '0;
         bit_cnt  <= '0;
         p_cfg    <= '0;
         cfg      <= '0;
      end else begin
         state    <= state_nxt;
         edge_cnt <= edge_nxt;
         bit_cnt  <= bit_nxt;
         p_cfg    <= p_nxt;
         cfg      <= cfg_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      edge_nxt  = edge_cnt;
      bit_nxt   = bit_cnt;
      p_nxt     = p_cfg;
      cfg_nxt   = cfg;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nxt = RUN;
               capture   = 1'b1;
               edge_nxt  = '0;
               bit_nxt   = '0;
            end
         end
         RUN: begin
            if (!enable) begin
               // Abort: drop straight to idle, no frame_done.
               state_nxt = IDLE;
               edge_nxt  = '0;
               bit_nxt   = '0;
            end else if (bit_done) begin
               edge_nxt = '0;
               if (frame_done) begin
                  bit_nxt = '0;
                  capture = 1'b1;
               end else begin
                  bit_nxt = bit_cnt + BWIDTH'(1);
               end
            end else begin
               edge_nxt = edge_cnt + PWIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (capture) begin
         p_nxt            = (prescale < PWIDTH'(MIN_PRESCALE)) ? PWIDTH'(MIN_PRESCALE) : prescale;
         cfg_nxt.data_len = clamp_data(data_len);
         cfg_nxt.par_en   = par_en;
         cfg_nxt.stop2    = stop2;
      end
   end

   assign busy         = (state == RUN);
   assign edge_counter = edge_cnt;
   assign bit_counter  = bit_cnt;

   rx_sample_decode #(.PWIDTH(PWIDTH), .BWIDTH(BWIDTH)) u_decode (
      .busy         (busy),
      .edge_counter (edge_cnt),
      .bit_counter  (bit_cnt),
      .prescale     (p_cfg),
      .cfg          (cfg),
      .field        (field),
      .samp_strobe  (samp_strobe),
      .bit_done     (bit_done),
      .frame_done   (frame_done)
   );

endmodule

// File: tb/tb_rx_frame_timer.sv
// Bench for rx_frame_timer: per-cycle reference model (single cycle count
// within the frame, div/mod for edge/bit), frame table and directed corners.
module tb_rx_frame_timer;

   logic       clk, rst, enable, par_en, stop2;
   logic [5:0] prescale;
   logic [3:0] data_len;
   logic [5:0] edge_counter;
   logic [3:0] bit_counter;
   logic [1:0] field;
   logic       busy, bit_done, frame_done;
   logic [2:0] samp_strobe;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   rx_frame_timer #(.PWIDTH(6), .BWIDTH(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .prescale(prescale),
      .data_len(data_len), .par_en(par_en), .stop2(stop2),
      .edge_counter(edge_counter), .bit_counter(bit_counter), .field(field),
      .busy(busy), .samp_strobe(samp_strobe), .bit_done(bit_done),
      .frame_done(frame_done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Reference model: running flag, cycle index inside frame, captured config.
   bit m_run = 0;
   int m_c = 0, m_p = 0, m_dl = 0, m_par = 0, m_st = 0;

   function automatic int m_n();
      return 2 + m_dl + m_par + m_st;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_run <= 0; m_c <= 0; m_p <= 0; m_dl <= 0; m_par <= 0; m_st <= 0;
      end else if (!m_run || (enable && m_c + 1 == m_p * m_n())) begin
         if (enable) begin
            m_run <= 1;
            m_c   <= 0;
            m_p   <= (prescale < 4) ? 4 : int'(prescale);
            m_dl  <= (data_len < 5) ? 5 : (data_len > 8) ? 8 : int'(data_len);
            m_par <= int'(par_en);
            m_st  <= int'(stop2);
         end else begin
            m_run <= 0;
            m_c   <= 0;
         end
      end else if (!enable) begin
         m_run <= 0;
         m_c   <= 0;
      end else begin
         m_c <= m_c + 1;
      end
   end

   function automatic logic [17:0] model_out();
      int e, b, h;
      logic [1:0] f;
      logic [2:0] s;
      logic bd, fd;
      if (!m_run) return '0;
      e = m_c % m_p;
      b = m_c / m_p;
      h = m_p / 2;
      if (b == 0)                      f = 2'd0;
      else if (b <= m_dl)              f = 2'd1;
      else if (m_par == 1 && b == m_dl + 1) f = 2'd2;
      else                             f = 2'd3;
      s  = {e == h + 1, e == h, e == h - 1};
      bd = (e == m_p - 1);
      fd = bd && (b == m_n() - 1);
      return {6'(e), 4'(b), f, 1'b1, s, bd, fd};
   endfunction

   function automatic logic [17:0] dut_out();
      return {edge_counter, bit_counter, field, busy, samp_strobe, bit_done, frame_done};
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         n_tests++;
         if (dut_out() !== model_out()) begin
            n_fail++;
            $display("FAIL model t=%0t got=%h exp=%h", $time, dut_out(), model_out());
         end
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int p, dl, par, st;
      int exp_p, exp_n, exp_s0;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int cyc, bd_cnt, s0, fd_bit, fd_edge, guard, cyc2;
      bit done, fd_seen;

      vecs[0] = '{8, 8, 0, 0, 8, 10, 3};
      vecs[1] = '{16, 7, 1, 1, 16, 11, 7};
      vecs[2] = '{2, 3, 0, 0, 4, 7, 1};
      vecs[3] = '{5, 9, 1, 0, 5, 11, 1};
      vecs[4] = '{63, 5, 0, 1, 63, 8, 30};

      rst = 0; enable = 0; prescale = 8; data_len = 8; par_en = 0; stop2 = 0;
      chk_en = 1;
      #12;
      check("reset outputs", int'(dut_out()), 0);
      #8 rst = 1;
      tick();

      // Frame table: cycle count, final counters, bit_done count, first strobe.
      for (int i = 0; i < 5; i++) begin
         prescale = 6'(vecs[i].p); data_len = 4'(vecs[i].dl);
         par_en = 1'(vecs[i].par); stop2 = 1'(vecs[i].st);
         enable = 1;
         cyc = 0; bd_cnt = 0; s0 = -1; done = 0; fd_bit = -1; fd_edge = -1;
         while (!done && cyc < 2000) begin
            tick();
            if (busy) cyc++;
            if (bit_done) bd_cnt++;
            if (samp_strobe == 3'b001 && s0 < 0) s0 = int'(edge_counter);
            if (cyc == 3) begin
               prescale = 6'd32; data_len = 4'($urandom); par_en = ~par_en;
            end
            if (frame_done) begin
               done = 1; fd_bit = int'(bit_counter); fd_edge = int'(edge_counter);
               enable = 0;
            end
         end
         check("frame_done seen", int'(done), 1);
         check("frame cycles", cyc, vecs[i].exp_p * vecs[i].exp_n);
         check("frame_done bit", fd_bit, vecs[i].exp_n - 1);
         check("frame_done edge", fd_edge, vecs[i].exp_p - 1);
         check("bit_done count", bd_cnt, vecs[i].exp_n);
         check("strobe0 edge", s0, vecs[i].exp_s0);
         tick();
         check("idle after frame", int'(busy), 0);
      end

      // Abort at bit 4, edge 2.
      prescale = 8; data_len = 8; par_en = 0; stop2 = 0; enable = 1;
      fd_seen = 0; guard = 0;
      do begin
         tick(); guard++;
         if (frame_done) fd_seen = 1;
      end while (!(bit_counter == 4 && edge_counter == 2) && guard < 200);
      check("abort reach point", int'(guard < 200), 1);
      enable = 0;
      tick();
      check("abort busy", int'(busy), 0);
      check("abort counters", int'({edge_counter, bit_counter}), 0);
      check("abort no frame_done", int'(fd_seen | frame_done), 0);
      enable = 1;
      tick();
      check("restart state", int'({busy, edge_counter, bit_counter}), 1 << 10);
      enable = 0;
      tick();

      // Back-to-back frames with prescale changed mid first frame.
      prescale = 8; data_len = 5; par_en = 0; stop2 = 0; enable = 1;
      cyc = 0;
      do begin
         tick(); cyc++;
         if (cyc == 10) prescale = 16;
      end while (!frame_done && cyc < 500);
      check("b2b first frame cycles", cyc, 56);
      tick();
      check("b2b second start", int'({busy, edge_counter, bit_counter}), 1 << 10);
      cyc2 = 1;
      while (!frame_done && cyc2 < 500) begin
         tick(); cyc2++;
      end
      check("b2b second frame cycles", cyc2, 112);
      enable = 0;
      tick();

      // Async reset mid bit 6.
      prescale = 8; data_len = 8; enable = 1; guard = 0;
      do begin tick(); guard++; end while (bit_counter != 6 && guard < 200);
      #2 rst = 0;
      #1 check("async reset outputs", int'(dut_out()), 0);
      tick(); tick();
      check("held in reset", int'(busy), 0);
      rst = 1;
      tick();
      check("resume after reset", int'({busy, edge_counter, bit_counter}), 1 << 10);
      enable = 0;
      tick();

      // Random traffic against the model.
      for (int k = 0; k < 4000; k++) begin
         if ($urandom % 8 == 0) begin
            prescale = ($urandom % 4 == 0) ? 6'($urandom) : 6'($urandom % 12);
            data_len = 4'($urandom);
            par_en   = 1'($urandom);
            stop2    = 1'($urandom);
         end
         enable = ($urandom % 40) != 0;
         if ($urandom % 700 == 0) begin
            rst = 0;
            tick();
            rst = 1;
         end
         tick();
      end

      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_frame_timer.md
Name: rx_frame_timer

Overview:
- Parametrised successor to the UART receiver's edge/bit counter.
- Generates oversampled edge and bit counts for a full UART RX frame: start bit, 5-8 data bits, optional parity bit, and 1 or 2 stop bits.
- Decodes three majority-vote sample strobes, a field indicator, and bit/frame completion pulses.
- Sits between the RX control FSM, which drives enable, and the data sampler, deserializer and checkers.

Parameters:
- PWIDTH, 6, width of prescale and edge_counter; oversampling ratio range 4..2^PWIDTH-1.
- BWIDTH, 4, width of bit_counter; must hold a maximum frame of 12 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  frame counting request from the RX FSM.
- prescale  in  PWIDTH  oversampling ratio (clocks per bit).
- data_len  in  4  number of data bits, 5..8.
- par_en  in  1  parity bit present.
- stop2  in  1  two stop bits when 1.
- edge_counter  out  PWIDTH  clock position within the current bit, 0..prescale-1.
- bit_counter  out  BWIDTH  bit index within the frame, 0..N-1.
- field  out  2  current bit type: 0 START, 1 DATA, 2 PARITY, 3 STOP.
- busy  out  1  a frame is being timed.
- samp_strobe  out  3  one-hot majority-vote sample points.
- bit_done  out  1  last clock of the current bit.
- frame_done  out  1  last clock of the frame.

Behaviour:
- Reset (rst=0, asynchronous): edge_counter=0, bit_counter=0, busy=0, config registers=0. Decoded outputs are all 0: field=START, samp_strobe=0, bit_done=0, frame_done=0.
- States: IDLE (busy=0) and RUN (busy=1).
- IDLE -> RUN on the first clk edge with enable=1.
  - At that edge, capture prescale, data_len, par_en and stop2 into config registers. Set edge_counter=0 and bit_counter=0.
  - Config input changes while in RUN are ignored until the next capture.
- Clamping at capture:
  - prescale<4 is captured as 4.
  - data_len<5 is captured as 5; data_len>8 is captured as 8.
- Frame length: N = 1 + data_len + par_en + 1 + stop2, giving a range of 7..12.
- RUN, each edge with enable=1:
  - If edge_counter = P-1 (P = captured prescale): edge_counter <- 0 and bit_counter increments.
  - Otherwise edge_counter increments.
- End of frame (bit_counter=N-1 and edge_counter=P-1):
  - Both counters go to 0.
  - If enable is still high, stay in RUN and re-capture config at that same edge (back-to-back frames with no gap).
  - If enable is low, go to IDLE.
- enable=0 while in RUN: at the next edge go to IDLE with counters=0. No frame_done is generated (abort).
- All decoded outputs are combinational from registered state and are forced to 0 in IDLE.
  - Exception: field reads START (0) in IDLE.
- samp_strobe, with h = P>>1:
  - bit0 when edge_counter = h-1.
  - bit1 when edge_counter = h.
  - bit2 when edge_counter = h+1.
  - Example for P=8: edges 3, 4, 5.
- bit_done = busy && edge_counter = P-1.
- frame_done = bit_done && bit_counter = N-1.
- field decode:
  - bit_counter=0 -> START.
  - 1..data_len -> DATA.
  - data_len+1 -> PARITY when par_en=1.
  - All remaining bits -> STOP.
- No wrap beyond N-1. bit_counter never exceeds 11.
- Reset asserted mid-frame clears everything immediately. No pulses are emitted.

Decomposition:
- Shared package (uart_pkg) holds:
  - field encodings FIELD_START/DATA/PARITY/STOP;
  - MIN_PRESCALE=4, MIN_DATA=5, MAX_DATA=8, MAX_FRAME=12.
- One natural sub-module, rx_sample_decode: combinational decode of samp_strobe, bit_done, frame_done and field from counters plus captured config. The counter/FSM stays in the top module.

Test Plan:
- Basic frame: rst low 20ns then high; prescale=8, data_len=8, par_en=0, stop2=0; enable=1 held.
  - busy rises after the first edge.
  - samp_strobe hits edges 3/4/5 of each bit.
  - bit_done occurs 10 times.
  - frame_done occurs once, on the 80th busy cycle, with bit_counter=9 and edge_counter=7.
- Full config: prescale=16, data_len=7, par_en=1, stop2=1 -> N=11.
  - field sequence: START, DATA×7, PARITY, STOP×2.
  - frame_done on the 176th busy cycle.
  - Strobes at edges 7/8/9.
- Clamping: prescale=2, data_len=3 -> captured P=4, N=7.
  - Strobes at edges 1/2/3.
  - frame_done after 28 cycles.
  - Changing prescale to 32 mid-frame has no effect.
- Abort: enable dropped at bit 4, edge 2.
  - Next edge: busy=0 and counters=0.
  - No frame_done.
  - Re-enable starts a fresh frame at bit 0.
- Back-to-back frames: enable held through 2 frames, with prescale changed to 16 before the first frame_done.
  - Second frame starts the cycle after the first frame_done, at bit 0 / edge 0.
  - Second frame uses P=16.
- Async reset: rst driven low mid-cycle during bit 6.
  - All outputs go to 0 immediately, without waiting for clk.
  - Counting resumes from 0 only after rst goes high with enable=1.
